// File: rtl/riscv_dm_pkg.sv
// rtl/riscv_dm_pkg.sv - DMI/DTMCS types, op codes and DTM constants shared by the debug transport
package riscv_dm_pkg;

    localparam int DMI_ADDR_WIDTH = 9;
    localparam int DMI_DATA_WIDTH = 32;
    localparam int DMI_OP_WIDTH   = 2;
    localparam int DMI_WIDTH      = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH;

    localparam logic [1:0] WR_OP_NOP = 2'd0;
    localparam logic [1:0] WR_OP_RD  = 2'd1;
    localparam logic [1:0] WR_OP_WR  = 2'd2;

    localparam logic [1:0] RD_OP_SUCCESS = 2'd0;
    localparam logic [1:0] RD_OP_FAILED  = 2'd2;
    localparam logic [1:0] RD_OP_BUSY    = 2'd3;

    localparam logic [3:0] DTM_VERSION     = 4'd1;
    localparam logic [2:0] DTM_IDLE_CYCLES = 3'd2;

    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;

    localparam logic [1:0] DMISTAT_OK     = 2'd0;
    localparam logic [1:0] DMISTAT_FAILED = 2'd2;
    localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

    typedef struct packed {
        logic [DMI_ADDR_WIDTH-1:0] addr;
        logic [DMI_DATA_WIDTH-1:0] data;
        logic [DMI_OP_WIDTH-1:0]   op;
    } dmi_t;

    typedef struct packed {
        logic [10:0] zero1;
        logic [2:0]  errinfo;
        logic        dtmhardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } dtm_state_e;

endpackage

// File: rtl/riscv_dtm_dmi.sv
// rtl/riscv_dtm_dmi.sv - DTMCS/DMI scan registers turned into single-outstanding DMI transactions
module riscv_dtm_dmi
    import riscv_dm_pkg::*;
#(
    parameter int ABITS = DMI_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_dtmcs_i,
    input  logic                 sel_dmi_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [DMI_WIDTH-1:0] dmi_req_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_op_i,
    output logic                 dmi_hardreset_o
);

    dtm_state_e                state_q, state_d;
    logic [1:0]                dmistat_q, dmistat_d;
    logic [31:0]               dtmcs_sr_q, dtmcs_sr_d;
    logic [DMI_WIDTH-1:0]      dmi_sr_q, dmi_sr_d;
    logic [DMI_ADDR_WIDTH-1:0] last_addr_q;
    logic [31:0]               last_data_q;
    dmi_t                      req_q;
    dmi_t                      dmi_scan;
    dtmcs_t                    dtmcs_cap;
    logic                      tdo_q, tdo_d;
    logic                      hardreset_q;

    logic busy;
    logic dtmcs_update, hard_req, soft_req;
    logic dmi_capture, dmi_update, issue;
    logic resp_fire;

    assign busy         = (state_q != IDLE);
    assign dmi_scan     = dmi_sr_q;
    assign dtmcs_update = update_dr_i & sel_dtmcs_i;
    assign hard_req     = dtmcs_update & dtmcs_sr_q[DTMCS_HARDRESET_BIT];
    assign soft_req     = dtmcs_update & ~dtmcs_sr_q[DTMCS_HARDRESET_BIT]
                                       & dtmcs_sr_q[DTMCS_DMIRESET_BIT];
    assign dmi_capture  = capture_dr_i & sel_dmi_i;
    assign dmi_update   = update_dr_i & sel_dmi_i;
    assign resp_fire    = (state_q == WAIT) & dmi_resp_valid_i;

    // Only a clean, idle DMI accepts a new RD/WR; NOP and op 3 are dropped silently.
    assign issue = dmi_update && (dmistat_q == DMISTAT_OK) && !busy &&
                   ((dmi_scan.op == WR_OP_RD) || (dmi_scan.op == WR_OP_WR));

    always_comb begin
        dtmcs_cap              = '0;
        dtmcs_cap.idle         = DTM_IDLE_CYCLES;
        dtmcs_cap.dmistat      = dmistat_q;
        dtmcs_cap.abits        = 6'(ABITS);
        dtmcs_cap.version      = DTM_VERSION;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = REQ;
            REQ:     if (dmi_req_ready_i) state_d = WAIT;
            WAIT:    if (dmi_resp_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hard_req) begin
            state_d = IDLE;
        end
    end

    assign dmi_req_valid_o  = (state_q == REQ);
    assign dmi_resp_ready_o = (state_q != REQ);
    assign dmi_req_o        = req_q;
    assign tdo_o            = tdo_q;
    assign dmi_hardreset_o  = hardreset_q;

    // Later assignments win: explicit resets beat busy, busy beats a failed response.
    always_comb begin
        dmistat_d = dmistat_q;
        if (resp_fire && (dmi_resp_op_i == RD_OP_FAILED) && (dmistat_q != DMISTAT_BUSY)) begin
            dmistat_d = DMISTAT_FAILED;
        end
        if (dmi_capture && busy) begin
            dmistat_d = DMISTAT_BUSY;
        end
        if (dmi_update && (dmistat_q == DMISTAT_OK) && busy) begin
            dmistat_d = DMISTAT_BUSY;
        end
        if (hard_req || soft_req) begin
            dmistat_d = DMISTAT_OK;
        end
    end

    always_comb begin
        dtmcs_sr_d = dtmcs_sr_q;
        dmi_sr_d   = dmi_sr_q;
        if (sel_dtmcs_i) begin
            if (capture_dr_i) begin
                dtmcs_sr_d = dtmcs_cap;
            end else if (shift_dr_i) begin
                dtmcs_sr_d = {tdi_i, dtmcs_sr_q[31:1]};
            end
        end
        if (sel_dmi_i) begin
            if (capture_dr_i) begin
                dmi_sr_d = busy ? {last_addr_q, last_data_q, RD_OP_BUSY}
                                : {last_addr_q, last_data_q, dmistat_q};
            end else if (shift_dr_i) begin
                dmi_sr_d = {tdi_i, dmi_sr_q[DMI_WIDTH-1:1]};
            end
        end
        tdo_d = 1'b0;
        if (sel_dtmcs_i) begin
            tdo_d = dtmcs_sr_d[0];
        end else if (sel_dmi_i) begin
            tdo_d = dmi_sr_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmistat_q   <= DMISTAT_OK;
            dtmcs_sr_q  <= '0;
            dmi_sr_q    <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            req_q       <= '0;
            tdo_q       <= 1'b0;
            hardreset_q <= 1'b0;
        end else begin
            dmistat_q   <= dmistat_d;
            dtmcs_sr_q  <= dtmcs_sr_d;
            dmi_sr_q    <= dmi_sr_d;
            tdo_q       <= tdo_d;
            hardreset_q <= hard_req;
            if (issue) begin
                req_q       <= dmi_scan;
                last_addr_q <= dmi_scan.addr;
            end
            // Writes keep last_data; responses arriving in IDLE are stray and discarded.
            if (resp_fire && (req_q.op == WR_OP_RD)) begin
                last_data_q <= dmi_resp_data_i;
            end
        end
    end

endmodule

// File: doc/riscv_dtm_dmi.md
# riscv_dtm_dmi

Debug Transport Module DMI front end. It owns the DTMCS and DMI data registers behind an already-decoded JTAG TAP and converts DMI scans into single-outstanding request/response transactions toward the Debug Module register file. It tracks sticky DMI status, `dmireset` and `dtmhardreset`. It runs entirely in the system clock domain; TAP events arrive as one-cycle strobes.

## Interface
- `ABITS`, default `DMI_ADDR_WIDTH` (9): DMI address width, reported in `dtmcs.abits`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sel_dtmcs_i`  in  1  IR currently selects DTMCS (0x10).
- `sel_dmi_i`  in  1  IR currently selects DMI (0x11). Never high together with `sel_dtmcs_i`.
- `capture_dr_i`, `shift_dr_i`, `update_dr_i`  in  1 each  one-cycle TAP strobes. At most one is high in any cycle.
- `tdi_i`  in  1  serial data in, sampled when `shift_dr_i` is high.
- `tdo_o`  out  1  bit 0 of the selected shift register; 0 when neither register is selected.
- `dmi_req_valid_o`  out  1  request valid.
- `dmi_req_ready_i`  in  1  DM accepts the request.
- `dmi_req_o`  out  `DMI_WIDTH`  `dmi_t`: addr, data, op (`WR_OP_RD`/`WR_OP_WR` only).
- `dmi_resp_valid_i`  in  1  DM response valid.
- `dmi_resp_ready_o`  out  1  response accept.
- `dmi_resp_data_i`  in  32  read data.
- `dmi_resp_op_i`  in  2  `RD_OP_SUCCESS` or `RD_OP_FAILED`.
- `dmi_hardreset_o`  out  1  one-cycle pulse requesting a DM interface reset.

## Operation
- State machine `IDLE → REQ → WAIT → IDLE`. "Busy" means the registered state is not `IDLE`.
- `dmistat` is a 2-bit sticky register: 0 = ok, 2 = failed, 3 = busy. Once nonzero, it holds until `dmireset` or `dtmhardreset`.
- Shift: the selected register does `sr <= {tdi_i, sr[W-1:1]}`, where W = 32 for DTMCS and `DMI_WIDTH` for DMI.
- DTMCS capture loads `{11'0, errinfo=0, 0, 0, 0, DTM_IDLE_CYCLES, dmistat, ABITS, DTM_VERSION}`.
- DTMCS update:
  - If bit 17 (`dtmhardreset`) is set: clear `dmistat`, force `IDLE`, drop `dmi_req_valid_o`, pulse `dmi_hardreset_o`.
  - Else if bit 16 (`dmireset`) is set: clear `dmistat` only.
- DMI capture:
  - If busy: load op = `RD_OP_BUSY` and set `dmistat = 3`.
  - Otherwise: load `{last_addr, last_data, dmistat}`.
- DMI update:
  - Ignored if `dmistat != 0`.
  - If busy: set `dmistat = 3` and ignore the update.
  - Else if op is `WR_OP_RD` or `WR_OP_WR`: latch addr, data and op into `dmi_req_o`; set `last_addr` to that addr; go to `REQ`.
  - Op `NOP` or 3: no action.
- `REQ`: hold `dmi_req_valid_o` and a stable `dmi_req_o` until `dmi_req_ready_i`, then go to `WAIT`.
- `WAIT`: `dmi_resp_ready_o = 1`. On `dmi_resp_valid_i`:
  - Read: `last_data <= dmi_resp_data_i`. A write leaves `last_data` unchanged.
  - If `dmi_resp_op_i == RD_OP_FAILED`: set `dmistat = 2`, unless it is already 3.
  - Go to `IDLE`.
- `IDLE`: `dmi_resp_ready_o = 1`; stray responses (after a hardreset) are consumed and discarded.

## Timing
- Reset values: state `IDLE`; `dmistat`, both shift registers, `last_addr`, `last_data`, `dmi_req_o` all 0; `tdo_o = 0`; `dmi_req_valid_o = 0`; `dmi_hardreset_o = 0`.
- `dmi_req_valid_o` rises the cycle after `update_dr_i`. The request is accepted in the cycle where valid and ready are both high.
- A response accepted in cycle N makes the block non-busy from cycle N+1. A DMI capture in cycle N still sees busy.
- `dmi_hardreset_o` is high exactly the cycle after the DTMCS update. Abandoning valid without ready is allowed only in this case.
- `tdo_o` is registered and changes the cycle after a capture or shift strobe.
- `rst` mid-transaction returns to `IDLE` next cycle with no pulse on `dmi_hardreset_o`.

## Structure
- Add to `riscv_dm_pkg`:
  - `dtm_state_e` (`IDLE`, `REQ`, `WAIT`).
  - `DTMCS_DMIRESET_BIT = 16`, `DTMCS_HARDRESET_BIT = 17`.
  - Existing `dmi_t`, `dtmcs_t`, op codes and DTM constants.
- Single module, no sub-modules. Both shift registers share the capture/shift/update decode.

## Test plan
- Read: DMI update `{addr=0x11, op=RD}`; DM is ready after 2 cycles and responds `data=0x00400382`, success → next capture shifts out `{0x11, 0x00400382, 0}`.
- Write: DMI update `{0x04, 0xDEADBEEF, WR}` → `dmi_req_o` matches exactly; valid is held stable while ready is low for 5 cycles.
- Busy: capture DMI while in `WAIT` → op field 3, `dmistat = 3`; a following RD update issues no request until a DTMCS update with bit 16 set.
- Failed: DM responds `RD_OP_FAILED` → DTMCS capture shows `dmistat = 2`, `abits = 9`, `version = 1`, `idle = 2`.
- Hardreset: DTMCS update with bit 17 during `REQ` → valid drops, `dmi_hardreset_o` pulses 1 cycle, state `IDLE`; a late response is consumed and `last_data` is unchanged.
- `rst` asserted during `WAIT` → all outputs at reset values next cycle.
